// File: rtl/fetch_pipe_if.sv
// Bus between fetch_pipe and its neighbours: controller enables, instruction memory and the
// pipeline words/PCs handed to the controller. Clock and reset stay outside the bundle.
interface fetch_pipe_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               PCwrite;
    logic               PCSel;
    logic [7:0]         branch_target;
    logic               IRload;
    logic               IR1_Sel;
    logic               IR3load;
    logic               IR4load;
    logic               PCWrite2;
    logic               PCWrite3;
    logic               IncCount;
    logic [7:0]         imem_rdata;
    logic [7:0]         imem_addr;
    logic [7:0]         Next_IR;
    logic [7:0]         IR;
    logic [7:0]         IR3;
    logic [7:0]         IR4;
    logic [7:0]         pc2;
    logic [7:0]         pc3;
    logic [COUNT_W-1:0] inst_count;
    logic               halted;

    // Controller and memory side.
    modport master (
        output PCwrite, PCSel, branch_target, IRload, IR1_Sel, IR3load, IR4load,
               PCWrite2, PCWrite3, IncCount, imem_rdata,
        input  imem_addr, Next_IR, IR, IR3, IR4, pc2, pc3, inst_count, halted
    );

    // Fetch pipeline side.
    modport slave (
        input  PCwrite, PCSel, branch_target, IRload, IR1_Sel, IR3load, IR4load,
               PCWrite2, PCWrite3, IncCount, imem_rdata,
        output imem_addr, Next_IR, IR, IR3, IR4, pc2, pc3, inst_count, halted
    );
endinterface

// File: rtl/fetch_pipe.sv
// Instruction fetch and pipeline registers: PC, IR/IR3/IR4 stages, in-flight PCs, instruction
// counter and STOP flag. Every load enable comes from the controller.
module fetch_pipe #(
    parameter logic [7:0]  NOP_WORD = 8'h0A,
    parameter int unsigned COUNT_W  = 16
) (
    input logic         clock,
    input logic         reset,
    fetch_pipe_if.slave bus
);

    localparam logic [3:0]         StopOpcode = 4'b0001;
    localparam logic [COUNT_W-1:0] CountOne   = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [7:0]         pc_q,     pc_d;
    logic [7:0]         ir_q,     ir_d;
    logic [7:0]         ir3_q,    ir3_d;
    logic [7:0]         ir4_q,    ir4_d;
    logic [7:0]         pc2_q,    pc2_d;
    logic [7:0]         pc3_q,    pc3_d;
    logic [COUNT_W-1:0] count_q,  count_d;
    logic               halted_q, halted_d;

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir3_d    = ir3_q;
        ir4_d    = ir4_q;
        pc2_d    = pc2_q;
        pc3_d    = pc3_q;
        count_d  = count_q;
        halted_d = halted_q;

        if (bus.PCwrite) begin
            pc_d = bus.PCSel ? (pc_q + 8'd1) : bus.branch_target;
        end

        // The halt flag follows the word entering IR, so a flush bubble clears it.
        if (bus.IRload) begin
            ir_d     = bus.IR1_Sel ? NOP_WORD : bus.imem_rdata;
            halted_d = (ir_d[3:0] == StopOpcode);
        end

        // Downstream stages take the pre-edge value of their upstream neighbour.
        if (bus.IR3load) begin
            ir3_d = ir_q;
        end
        if (bus.IR4load) begin
            ir4_d = ir3_q;
        end
        if (bus.PCWrite2) begin
            pc2_d = pc_q;
        end
        if (bus.PCWrite3) begin
            pc3_d = pc2_q;
        end

        if (bus.IncCount) begin
            count_d = count_q + CountOne;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= 8'h00;
            ir_q     <= NOP_WORD;
            ir3_q    <= NOP_WORD;
            ir4_q    <= NOP_WORD;
            pc2_q    <= 8'h00;
            pc3_q    <= 8'h00;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir3_q    <= ir3_d;
            ir4_q    <= ir4_d;
            pc2_q    <= pc2_d;
            pc3_q    <= pc3_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.Next_IR    = bus.imem_rdata;
    assign bus.IR         = ir_q;
    assign bus.IR3        = ir3_q;
    assign bus.IR4        = ir4_q;
    assign bus.pc2        = pc2_q;
    assign bus.pc3        = pc3_q;
    assign bus.inst_count = count_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: a vector table of control inputs with expected post-edge state, queued
// at drive time and compared one cycle later, plus hand sequences for halt/reset and wrap.
module tb_fetch_pipe;

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        pcsel;
        logic [7:0]  bt;
        logic        irl;
        logic        ir1;
        logic        ir3l;
        logic        ir4l;
        logic        pw2;
        logic        pw3;
        logic        inc;
        logic        ff;
        logic [7:0]  e_pc;
        logic [7:0]  e_ir;
        logic [7:0]  e_ir3;
        logic [7:0]  e_ir4;
        logic [7:0]  e_pc2;
        logic [7:0]  e_pc3;
        logic [15:0] e_cnt;
        logic        e_halt;
    } vec_t;

    localparam int NV = 15;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       mem_ff;
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    vec_t       vecs [NV];
    vec_t       exp_q [$];

    fetch_pipe_if #(.COUNT_W(16)) bus ();
    fetch_pipe_if #(.COUNT_W(4))  sbus ();

    fetch_pipe #(.NOP_WORD(8'h0A), .COUNT_W(16)) u_dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    fetch_pipe #(.NOP_WORD(8'h0A), .COUNT_W(4)) u_small (
        .clock (clock),
        .reset (rst_n),
        .bus   (sbus)
    );

    always #5 clock = ~clock;

    assign bus.imem_rdata  = mem_ff ? 8'hFF : mem[bus.imem_addr];
    assign sbus.imem_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        logic [7:0] e_next;
        rst_n             = v.rst;
        mem_ff            = v.ff;
        bus.PCwrite       = v.pcw;
        bus.PCSel         = v.pcsel;
        bus.branch_target = v.bt;
        bus.IRload        = v.irl;
        bus.IR1_Sel       = v.ir1;
        bus.IR3load       = v.ir3l;
        bus.IR4load       = v.ir4l;
        bus.PCWrite2      = v.pw2;
        bus.PCWrite3      = v.pw3;
        bus.IncCount      = v.inc;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e      = exp_q.pop_front();
        e_next = e.ff ? 8'hFF : mem[e.e_pc];
        check({tag, " imem_addr"},  32'(bus.imem_addr),  32'(e.e_pc));
        check({tag, " Next_IR"},    32'(bus.Next_IR),    32'(e_next));
        check({tag, " IR"},         32'(bus.IR),         32'(e.e_ir));
        check({tag, " IR3"},        32'(bus.IR3),        32'(e.e_ir3));
        check({tag, " IR4"},        32'(bus.IR4),        32'(e.e_ir4));
        check({tag, " pc2"},        32'(bus.pc2),        32'(e.e_pc2));
        check({tag, " pc3"},        32'(bus.pc3),        32'(e.e_pc3));
        check({tag, " inst_count"}, 32'(bus.inst_count), 32'(e.e_cnt));
        check({tag, " halted"},     32'(bus.halted),     32'(e.e_halt));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(8'h10 + i);
        end
        sbus.PCwrite = 1'b0; sbus.PCSel = 1'b0; sbus.branch_target = 8'h00;
        sbus.IRload = 1'b0; sbus.IR1_Sel = 1'b0; sbus.IR3load = 1'b0; sbus.IR4load = 1'b0;
        sbus.PCWrite2 = 1'b0; sbus.PCWrite3 = 1'b0; sbus.IncCount = 1'b0;

        // rst pcw sel bt irl ir1 ir3 ir4 pw2 pw3 inc ff | pc ir ir3 ir4 pc2 pc3 cnt halt
        vecs[0]  = '{0, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 1,
                     8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00, 16'd0, 0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h01, 8'h10, 8'h0A, 8'h0A, 8'h00, 8'h00, 16'd1, 0};
        vecs[3]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h02, 8'h11, 8'h10, 8'h0A, 8'h01, 8'h00, 16'd2, 1};
        vecs[4]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h03, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 16'd3, 0};
        vecs[5]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h04, 8'h13, 8'h12, 8'h11, 8'h03, 8'h02, 16'd4, 0};
        vecs[6]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h05, 8'h14, 8'h13, 8'h12, 8'h04, 8'h03, 16'd5, 0};
        // Branch taken at PC=05: flush IR, redirect to 40.
        vecs[7]  = '{1, 1, 0, 8'h40, 1, 1, 1, 1, 1, 1, 1, 0,
                     8'h40, 8'h0A, 8'h14, 8'h13, 8'h05, 8'h04, 16'd6, 0};
        vecs[8]  = '{1, 1, 1, 8'h00, 1, 0, 1, 1, 1, 1, 1, 0,
                     8'h41, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};
        // Stall; the later two also raise IR1_Sel, which must not touch IR.
        vecs[9]  = '{1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,
                     8'h41, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};
        vecs[10] = '{1, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0,
                     8'h41, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};
        vecs[11] = vecs[10];
        // PC wrap FE -> FF -> 00 with IR held.
        vecs[12] = '{1, 1, 0, 8'hFE, 0, 0, 0, 0, 0, 0, 0, 0,
                     8'hFE, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};
        vecs[13] = '{1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,
                     8'hFF, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};
        vecs[14] = '{1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,
                     8'h00, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Halt: jump to F1 (holds 8'h01), fetch it, then drop all loads.
        apply('{1, 1, 0, 8'hF1, 0, 0, 0, 0, 0, 0, 0, 0,
                8'hF1, 8'h50, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 0}, "halt_jump");
        apply('{1, 1, 1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,
                8'hF2, 8'h01, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 1}, "halt_fetch");
        for (int i = 0; i < 2; i++) begin
            apply('{1, 0, 0, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0,
                    8'hF2, 8'h01, 8'h0A, 8'h14, 8'h40, 8'h05, 16'd7, 1},
                  $sformatf("halt_hold%0d", i));
        end
        // Single-edge reset with every enable high still wins.
        apply('{0, 1, 0, 8'h33, 1, 0, 1, 1, 1, 1, 1, 0,
                8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00, 16'd0, 0}, "halt_reset");
        rst_n = 1'b1;
        bus.PCwrite = 1'b0; bus.IRload = 1'b0; bus.IR3load = 1'b0; bus.IR4load = 1'b0;
        bus.PCWrite2 = 1'b0; bus.PCWrite3 = 1'b0; bus.IncCount = 1'b0;

        // Counter wrap on the narrow instance: 15 increments reach all-ones, one more wraps.
        check("small reset count", 32'(sbus.inst_count), 32'h0);
        sbus.IncCount = 1'b1;
        repeat (15) @(posedge clock);
        #1;
        check("small count max", 32'(sbus.inst_count), 32'hF);
        @(posedge clock);
        #1;
        check("small count wrap", 32'(sbus.inst_count), 32'h0);
        sbus.IncCount = 1'b0;
        @(posedge clock);
        #1;
        check("small count hold", 32'(sbus.inst_count), 32'h0);
        check("main count idle", 32'(bus.inst_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
